// File: rtl/lfo_pkg.sv
// Shared LFO definitions: wave encodings, write addresses, sequencer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Imported by the LFO control sequencer, its main counter and the LFO core.
package lfo_pkg;

  // Width of the free-running main counter; the LFO slices from bit 26 down.
  localparam int MAIN_COUNTER_WIDTH = 27;

  // Width of the post-strobe hold down-counter (HOLD_CYCLES up to 15).
  localparam int HOLD_CNT_WIDTH = 4;

  // Wave-type register encodings.
  typedef enum logic [1:0] {
    SQUARE           = 2'b00,
    TRIANGLE         = 2'b01,
    SAWTOOTH         = 2'b10,
    REVERSE_SAWTOOTH = 2'b11
  } lfo_wave_t;

  // Parameter-write target addresses.
  localparam logic [1:0] ADDR_FREQ = 2'd0;
  localparam logic [1:0] ADDR_AMP  = 2'd1;
  localparam logic [1:0] ADDR_WAVE = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_t;

  // True for addresses that go through the SETUP/STROBE/HOLD sequence.
  function automatic logic is_strobed_addr(input logic [1:0] addr);
    return (addr == ADDR_FREQ) || (addr == ADDR_AMP);
  endfunction

endpackage

// File: rtl/lfo_main_counter.sv
// Free-running up-counter, wraps from all-ones to zero.
// Latency: count visible one cycle after each clock edge (registered output).
// Backpressure: none; counts every cycle.
//
// Ports:
//   i_clock  - clock
//   i_reset  - synchronous active-high reset, clears the count
//   o_count  - current count, WIDTH bits
module lfo_main_counter #(
  parameter int WIDTH = 27
) (
  input  logic             i_clock,
  input  logic             i_reset,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Natural modulo-2^WIDTH overflow provides the wrap to zero.
  always_comb begin
    count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/lfo_ctrl_sequencer.sv
// LFO control sequencer: valid/ready parameter writes -> shared data bus + freq/amp strobes.
// Latency: freq/amp write accepted at edge N strobes during cycle N+2; wave writes apply at edge N.
// Backpressure: o_wr_ready low for 2+HOLD_CYCLES cycles after a freq/amp write; wave/rsvd never stall.
//
// Ports:
//   i_clock, i_reset        - clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready   - write handshake; i_wr_addr (0 freq, 1 amp, 2 wave, 3 rsvd), i_wr_data
//   o_main_counter          - free-running COUNTER_WIDTH counter for the LFO compare logic
//   o_amplitude_freq_reg    - shared 8-bit data bus, stable from SETUP through HOLD
//   o_freq_en / o_amp_en    - one-cycle load strobes, never both high
//   o_wave_type_reg         - wave select register
//   o_params_loaded         - both freq and amp strobed since reset
//   o_err                   - sticky protocol error (wave data[7:2] nonzero, or reserved address)
//
// COUNTER_WIDTH must be at least 27 (the LFO slices bit 26 downward);
// HOLD_CYCLES must be in 1..15 to fit the 4-bit hold counter.
module lfo_ctrl_sequencer
  import lfo_pkg::*;
#(
  parameter int COUNTER_WIDTH = MAIN_COUNTER_WIDTH,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [1:0]               i_wr_addr,
  input  logic [7:0]               i_wr_data,
  output logic [COUNTER_WIDTH-1:0] o_main_counter,
  output logic [7:0]               o_amplitude_freq_reg,
  output logic                     o_freq_en,
  output logic                     o_amp_en,
  output logic [1:0]               o_wave_type_reg,
  output logic                     o_params_loaded,
  output logic                     o_err
);

  // Loaded on entry to HOLD; HOLD exits when it reaches zero, giving
  // exactly HOLD_CYCLES cycles in HOLD.
  localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LOAD = HOLD_CNT_WIDTH'(HOLD_CYCLES - 1);

  seq_state_t                state_q,         state_d;
  logic                      is_amp_q,        is_amp_d;
  logic [7:0]                bus_q,           bus_d;
  logic                      freq_en_q,       freq_en_d;
  logic                      amp_en_q,        amp_en_d;
  lfo_wave_t                 wave_q,          wave_d;
  logic [HOLD_CNT_WIDTH-1:0] hold_cnt_q,      hold_cnt_d;
  logic                      freq_seen_q,     freq_seen_d;
  logic                      amp_seen_q,      amp_seen_d;
  logic                      params_loaded_q, params_loaded_d;
  logic                      err_q,           err_d;

  // ---------------------------------------------------------------------------
  // Main counter: independent of the write FSM.
  // ---------------------------------------------------------------------------
  lfo_main_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_main_counter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_count (o_main_counter)
  );

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    is_amp_d   = is_amp_q;
    bus_d      = bus_q;
    freq_en_d  = 1'b0;
    amp_en_d   = 1'b0;
    wave_d     = wave_q;
    hold_cnt_d = hold_cnt_q;
    err_d      = err_q;

    // Sticky bits follow the registered strobes, so the AND below lands in
    // the cycle right after the second strobe.
    freq_seen_d     = freq_seen_q | freq_en_q;
    amp_seen_d      = amp_seen_q  | amp_en_q;
    params_loaded_d = freq_seen_d & amp_seen_d;

    unique case (state_q)
      ST_IDLE: begin
        // Ready is high in IDLE, so a valid request is accepted this edge.
        if (i_wr_valid) begin
          if (is_strobed_addr(i_wr_addr)) begin
            state_d  = ST_SETUP;
            is_amp_d = (i_wr_addr == ADDR_AMP);
            bus_d    = i_wr_data;
          end else if (i_wr_addr == ADDR_WAVE) begin
            // Low bits always apply; stray high bits only flag the error.
            wave_d = lfo_wave_t'(i_wr_data[1:0]);
            if (i_wr_data[7:2] != 6'd0) begin
              err_d = 1'b1;
            end
          end else if (i_wr_addr == ADDR_RSVD) begin
            err_d = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        // Strobe flops are loaded here so they are high during STROBE.
        state_d   = ST_STROBE;
        freq_en_d = ~is_amp_q;
        amp_en_d  = is_amp_q;
      end

      ST_STROBE: begin
        state_d    = ST_HOLD;
        hold_cnt_d = HOLD_LOAD;
      end

      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - {{(HOLD_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q         <= ST_IDLE;
      is_amp_q        <= 1'b0;
      bus_q           <= 8'h00;
      freq_en_q       <= 1'b0;
      amp_en_q        <= 1'b0;
      wave_q          <= SQUARE;
      hold_cnt_q      <= '0;
      freq_seen_q     <= 1'b0;
      amp_seen_q      <= 1'b0;
      params_loaded_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_amp_q        <= is_amp_d;
      bus_q           <= bus_d;
      freq_en_q       <= freq_en_d;
      amp_en_q        <= amp_en_d;
      wave_q          <= wave_d;
      hold_cnt_q      <= hold_cnt_d;
      freq_seen_q     <= freq_seen_d;
      amp_seen_q      <= amp_seen_d;
      params_loaded_q <= params_loaded_d;
      err_q           <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from flops; ready decodes the state register only.
  // ---------------------------------------------------------------------------
  assign o_wr_ready           = (state_q == ST_IDLE);
  assign o_amplitude_freq_reg = bus_q;
  assign o_freq_en            = freq_en_q;
  assign o_amp_en             = amp_en_q;
  assign o_wave_type_reg      = wave_q;
  assign o_params_loaded      = params_loaded_q;
  assign o_err                = err_q;

endmodule

// File: tb/tb_lfo_ctrl_sequencer.sv
module tb_lfo_ctrl_sequencer;

  localparam int CW   = 27;
  localparam int HOLD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_addr = 2'd0;
  logic [7:0]    wr_data = 8'h00;
  logic [CW-1:0] main_counter;
  logic [7:0]    bus;
  logic          freq_en;
  logic          amp_en;
  logic [1:0]    wave;
  logic          params_loaded;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit         is_amp;
    logic [7:0] data;
    int         at_cyc;
  } strobe_t;

  strobe_t sb[$];
  strobe_t mon_e;

  lfo_ctrl_sequencer #(
    .COUNTER_WIDTH (CW),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_wr_valid           (wr_valid),
    .o_wr_ready           (wr_ready),
    .i_wr_addr            (wr_addr),
    .i_wr_data            (wr_data),
    .o_main_counter       (main_counter),
    .o_amplitude_freq_reg (bus),
    .o_freq_en            (freq_en),
    .o_amp_en             (amp_en),
    .o_wave_type_reg      (wave),
    .o_params_loaded      (params_loaded),
    .o_err                (err)
  );

  always #20 clk = ~clk;

  // cyc = number of rising edges so far; stable when sampled on negedges.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every strobe must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && (freq_en === 1'b1 || amp_en === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected cyc=%0d freq_en=%b amp_en=%b bus=%h, required no strobe",
                 cyc, freq_en, amp_en, bus);
      end else begin
        mon_e = sb.pop_front();
        if (freq_en === amp_en || amp_en !== mon_e.is_amp || bus !== mon_e.data || cyc != mon_e.at_cyc) begin
          errors++;
          $display("FAIL strobe_match got freq_en=%b amp_en=%b bus=%h cyc=%0d, required amp=%0d bus=%h cyc=%0d",
                   freq_en, amp_en, bus, cyc, mon_e.is_amp, mon_e.data, mon_e.at_cyc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_write(input logic [1:0] a, input logic [7:0] d, output int acc_cyc);
    int guard;
    strobe_t e;
    guard = 0;
    acc_cyc = -1;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (wr_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("FAIL write_accept_timeout addr=%0d ready=%b, required 1 within 40 cycles", a, wr_ready);
    end else begin
      acc_cyc = cyc + 1;
      if (a == 2'd0 || a == 2'd1) begin
        e.is_amp = (a == 2'd1);
        e.data   = d;
        e.at_cyc = cyc + 2;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({wr_ready, freq_en, amp_en, bus, wave, params_loaded, err} !==
        {1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b fen=%b aen=%b bus=%h wave=%b pl=%b err=%b, required 1 0 0 00 00 0 0",
               wr_ready, freq_en, amp_en, bus, wave, params_loaded, err);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (main_counter !== CW'(k)) begin
        errors++;
        $display("FAIL reset_counter step=%0d got %h, required %h", k, main_counter, k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_freq_write();
    strobe_t e;
    logic [10:0] got;
    logic [10:0] exp;
    wr_valid = 1'b1;
    wr_addr  = 2'd0;
    wr_data  = 8'h40;
    e.is_amp = 1'b0;
    e.data   = 8'h40;
    e.at_cyc = cyc + 2;
    sb.push_back(e);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) wr_valid = 1'b0;
      got = {wr_ready, freq_en, amp_en, bus};
      exp = {(k == 5), (k == 2), 1'b0, 8'h40};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL freq_write N+%0d got rdy/fen/aen/bus=%b/%b/%b/%h, required %b/%b/%b/%h",
                 k, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_wave_writes();
    int acc;
    do_write(2'd2, 8'h02, acc);
    checks++;
    if ({wave, wr_ready, err} !== {2'b10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wave_write_02 got wave=%b rdy=%b err=%b, required 10 1 0", wave, wr_ready, err);
    end
    do_write(2'd2, 8'h83, acc);
    checks++;
    if ({wave, wr_ready, err} !== {2'b11, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wave_write_83 got wave=%b rdy=%b err=%b, required 11 1 1", wave, wr_ready, err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({wave, err, bus} !== {2'b11, 1'b1, 8'h40}) begin
      errors++;
      $display("FAIL wave_err_sticky got wave=%b err=%b bus=%h, required 11 1 40", wave, err, bus);
    end
  endtask

  task automatic test_freq_then_amp();
    int acc0;
    int acc1;
    do_write(2'd0, 8'h10, acc0);
    do_write(2'd1, 8'h7F, acc1);
    checks++;
    if (acc1 - acc0 != 3 + HOLD) begin
      errors++;
      $display("FAIL freq_amp_spacing got %0d cycles, required %0d", acc1 - acc0, 3 + HOLD);
    end
    @(negedge clk);
    checks++;
    if ({amp_en, freq_en, params_loaded, bus} !== {1'b1, 1'b0, 1'b0, 8'h7F}) begin
      errors++;
      $display("FAIL amp_strobe got aen=%b fen=%b pl=%b bus=%h, required 1 0 0 7f",
               amp_en, freq_en, params_loaded, bus);
    end
    @(negedge clk);
    checks++;
    if ({amp_en, params_loaded} !== 2'b01) begin
      errors++;
      $display("FAIL params_loaded got aen=%b pl=%b, required 0 1", amp_en, params_loaded);
    end
    while (wr_ready !== 1'b1 && cyc < 5000) @(negedge clk);
  endtask

  task automatic test_reset_during_write();
    int amp_hits;
    amp_hits = 0;
    wr_valid = 1'b1;
    wr_addr  = 2'd1;
    wr_data  = 8'h55;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if ({wr_ready, bus} !== {1'b0, 8'h55}) begin
      errors++;
      $display("FAIL abort_setup got rdy=%b bus=%h, required 0 55", wr_ready, bus);
    end
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      if (amp_en === 1'b1) amp_hits++;
    end
    checks++;
    if (amp_hits != 0) begin
      errors++;
      $display("FAIL abort_no_strobe got %0d amp_en pulses, required 0", amp_hits);
    end
    checks++;
    if ({bus, params_loaded, wr_ready, err} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_state got bus=%h pl=%b rdy=%b err=%b, required 00 0 1 0",
               bus, params_loaded, wr_ready, err);
    end
  endtask

  task automatic test_back_to_back_wave();
    int acc;
    int prev;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      do_write(2'd2, 8'(3 - i), acc);
      checks++;
      if (wave !== 2'(3 - i) || err !== 1'b0 || (prev >= 0 && acc - prev != 1)) begin
        errors++;
        $display("FAIL b2b_wave i=%0d got wave=%b err=%b spacing=%0d, required %b 0 1",
                 i, wave, err, acc - prev, 2'(3 - i));
      end
      prev = acc;
    end
  endtask

  task automatic test_reserved_addr();
    int acc;
    do_write(2'd3, 8'hAA, acc);
    checks++;
    if ({err, wave, bus, wr_ready, freq_en, amp_en} !== {1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reserved_addr got err=%b wave=%b bus=%h rdy=%b fen=%b aen=%b, required 1 00 00 1 0 0",
               err, wave, bus, wr_ready, freq_en, amp_en);
    end
  endtask

  task automatic test_counter_wrap();
    force dut.u_main_counter.count_q = 27'h7FFFFFF;
    #1;
    release dut.u_main_counter.count_q;
    #1;
    checks++;
    if (main_counter !== 27'h7FFFFFF) begin
      errors++;
      $display("FAIL wrap_preload got %h, required 7ffffff", main_counter);
    end
    @(negedge clk);
    checks++;
    if ({main_counter, wr_ready, freq_en, amp_en} !== {27'h0000000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_zero got cnt=%h rdy=%b fen=%b aen=%b, required 0000000 1 0 0",
               main_counter, wr_ready, freq_en, amp_en);
    end
    @(negedge clk);
    checks++;
    if (main_counter !== 27'h0000001) begin
      errors++;
      $display("FAIL wrap_next got %h, required 0000001", main_counter);
    end
  endtask

  initial begin
    test_reset();
    test_freq_write();
    test_wave_writes();
    test_freq_then_amp();
    test_reset_during_write();
    test_back_to_back_wave();
    test_reserved_addr();
    pulse_reset();
    test_counter_wrap();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending strobes, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
